// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through byte FIFO onto the TX pin.
// Each frame has a start bit, 8 data bits sent LSB first, an optional parity bit and a stop bit.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             pop_q, pop_d;
    logic             baud_last_s;
    logic [2:0]       bit_next_s;

    // Parity bit for the configured mode: even -> XOR of the byte, odd -> its inverse.
    function automatic logic parity_of(input logic [7:0] b);
        logic p;
        p = ^b;
        if (PARITY == 2) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    // Next-state, next-output and counter logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        pop_d       = 1'b0;
        baud_last_s = (baud_q == BAUD_LAST);
        bit_next_s  = bit_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_ZERO;
                bit_d  = 3'd0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    pop_d   = 1'b1;
                    state_d = ST_START;
                end else begin
                    busy_d  = 1'b0;
                end
            end

            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = BAUD_ZERO;
                    bit_d  = bit_next_s;
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            tx_d    = parity_of(shift_q);
                            state_d = ST_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        tx_d = shift_q[bit_next_s];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                end
            end

            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = BAUD_ZERO;
                    bit_d  = 3'd0;
                    // A waiting byte starts the next frame on this edge with no idle gap.
                    if (!fifo_empty) begin
                        shift_d = fifo_data;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                        pop_d   = 1'b1;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end

            default: begin
                baud_d  = BAUD_ZERO;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset back to an idle line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            pop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            pop_q   <= pop_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign fifo_pop = pop_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no/even/odd parity) fed by queue FIFOs and
// checked every cycle against a line-waveform model built from the frame format.
module tb_uart_tx_fifo_drain;
    localparam int CPB = 4;
    localparam int N   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty [N];
    logic [7:0] fifo_data  [N];
    logic       fifo_pop   [N];
    logic       tx         [N];
    logic       busy       [N];

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_none (
        .clk(clk), .reset(reset), .fifo_data(fifo_data[0]), .fifo_empty(fifo_empty[0]),
        .fifo_pop(fifo_pop[0]), .tx(tx[0]), .busy(busy[0]));
    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_even (
        .clk(clk), .reset(reset), .fifo_data(fifo_data[1]), .fifo_empty(fifo_empty[1]),
        .fifo_pop(fifo_pop[1]), .tx(tx[1]), .busy(busy[1]));
    uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY(2)) u_odd (
        .clk(clk), .reset(reset), .fifo_data(fifo_data[2]), .fifo_empty(fifo_empty[2]),
        .fifo_pop(fifo_pop[2]), .tx(tx[2]), .busy(busy[2]));

    logic [7:0]  fq [N][$];
    bit          mq [N][$];
    int          checks = 0;
    int          errors = 0;
    int          cycle  = 0;
    int          pop_cnt  [N];
    int          busy_cnt [N];
    int          low_cnt  [N];
    int          rise_cnt [N];
    logic        prev_busy[N];
    logic [63:0] hist     [N];

    task automatic chk_bit(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d got %b expected %b", name, i, cycle, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input int i, input logic [63:0] act,
                           input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d got %0h expected %0h", name, i, cycle, act, exp);
        end
    endtask

    // Append the full line waveform of one frame, CPB samples per bit.
    task automatic build_frame(input int i, input logic [7:0] d);
        bit p;
        for (int k = 0; k < CPB; k++) mq[i].push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int k = 0; k < CPB; k++) mq[i].push_back(d[b]);
        if (i != 0) begin
            p = (($countones(d) % 2) == 1);
            if (i == 2) p = !p;
            for (int k = 0; k < CPB; k++) mq[i].push_back(p);
        end
        for (int k = 0; k < CPB; k++) mq[i].push_back(1'b1);
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() == 0) begin
                fifo_empty[i] = 1'b1;
                fifo_data[i]  = 8'($urandom);
            end else begin
                fifo_empty[i] = 1'b0;
                fifo_data[i]  = fq[i][0];
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            pop_cnt[i]   = 0;
            busy_cnt[i]  = 0;
            low_cnt[i]   = 0;
            rise_cnt[i]  = 0;
            hist[i]      = 64'h0;
            prev_busy[i] = busy[i];
        end
    endtask

    // One clock: advance the model on the inputs the DUT just sampled, compare, update FIFOs.
    task automatic step();
        @(negedge clk);
        cycle++;
        for (int i = 0; i < N; i++) begin
            logic ep;
            ep = 1'b0;
            if (reset) begin
                mq[i].delete();
            end else begin
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                if (mq[i].size() == 0 && !fifo_empty[i]) begin
                    build_frame(i, fifo_data[i]);
                    ep = 1'b1;
                end
            end
            chk_bit("tx", i, tx[i], (mq[i].size() == 0) ? 1'b1 : mq[i][0]);
            chk_bit("busy", i, busy[i], mq[i].size() != 0);
            chk_bit("fifo_pop", i, fifo_pop[i], ep);
            if (fifo_pop[i] === 1'b1) pop_cnt[i]++;
            if (busy[i] === 1'b1) busy_cnt[i]++;
            if (tx[i] === 1'b0) low_cnt[i]++;
            if (busy[i] === 1'b1 && prev_busy[i] !== 1'b1) rise_cnt[i]++;
            prev_busy[i] = busy[i];
            hist[i] = {hist[i][62:0], tx[i]};
            if (fifo_pop[i] === 1'b1 && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        drive_fifo();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] = 1'b1;
            fifo_data[i]  = 8'h00;
        end
        clear_stats();

        // Reset held with an empty FIFO, then released.
        repeat (10) step();
        reset = 1'b0;
        repeat (5) step();
        for (int i = 0; i < N; i++) begin
            chk_val("rst_pops", i, 64'(pop_cnt[i]), 64'd0);
            chk_val("rst_txlow", i, 64'(low_cnt[i]), 64'd0);
            chk_val("rst_busy", i, 64'(busy_cnt[i]), 64'd0);
        end

        // 0x55 without parity; 0x07 with even and odd parity.
        clear_stats();
        fq[0].push_back(8'h55);
        fq[1].push_back(8'h07);
        fq[2].push_back(8'h07);
        drive_fifo();
        repeat (40) step();
        chk_val("wave_55", 0, {24'h0, hist[0][39:0]}, 64'h0F0F0F0F0F);
        chk_val("pops_55", 0, 64'(pop_cnt[0]), 64'd1);
        chk_val("busy_55", 0, 64'(busy_cnt[0]), 64'd40);
        repeat (4) step();
        chk_val("wave_07_even", 1, {20'h0, hist[1][43:0]}, 64'h0FFF00000FF);
        chk_val("wave_07_odd", 2, {20'h0, hist[2][43:0]}, 64'h0FFF000000F);
        chk_val("parity_even", 1, {60'h0, hist[1][7:4]}, 64'hF);
        chk_val("parity_odd", 2, {60'h0, hist[2][7:4]}, 64'h0);
        for (int i = 1; i < N; i++) begin
            chk_val("busy_07", i, 64'(busy_cnt[i]), 64'd44);
            chk_val("pops_07", i, 64'(pop_cnt[i]), 64'd1);
        end
        chk_val("idle_after_55", 0, 64'(busy_cnt[0]), 64'd40);
        repeat (4) step();

        // Two bytes queued: back-to-back frames, one busy period.
        clear_stats();
        for (int i = 0; i < N; i++) begin
            fq[i].push_back(8'h00);
            fq[i].push_back(8'hFF);
        end
        drive_fifo();
        repeat (100) step();
        for (int i = 0; i < N; i++) begin
            chk_val("b2b_pops", i, 64'(pop_cnt[i]), 64'd2);
            chk_val("b2b_busy", i, 64'(busy_cnt[i]), (i == 0) ? 64'd80 : 64'd88);
            chk_val("b2b_rises", i, 64'(rise_cnt[i]), 64'd1);
            chk_bit("b2b_idle", i, busy[i], 1'b0);
        end

        // Reset during data bit 3 of 0xA5.
        clear_stats();
        for (int i = 0; i < N; i++) fq[i].push_back(8'hA5);
        drive_fifo();
        repeat (18) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk_bit("midrst_tx", i, tx[i], 1'b1);
            chk_bit("midrst_busy", i, busy[i], 1'b0);
        end
        repeat (60) step();
        for (int i = 0; i < N; i++) begin
            chk_val("midrst_pops", i, 64'(pop_cnt[i]), 64'd1);
            chk_val("midrst_busy_cnt", i, 64'(busy_cnt[i]), 64'd18);
            chk_val("midrst_low_cnt", i, 64'(low_cnt[i]), 64'd10);
        end

        // Long empty period.
        clear_stats();
        repeat (1000) step();
        for (int i = 0; i < N; i++) begin
            chk_val("empty_pops", i, 64'(pop_cnt[i]), 64'd0);
            chk_val("empty_txlow", i, 64'(low_cnt[i]), 64'd0);
        end

        // Random pushes, garbage data while empty, occasional resets.
        repeat (4000) begin
            for (int i = 0; i < N; i++) begin
                if (fq[i].size() < 3 && $urandom_range(0, 29) == 0)
                    fq[i].push_back(8'($urandom));
            end
            reset = ($urandom_range(0, 799) == 0);
            drive_fifo();
            step();
        end
        reset = 1'b0;
        drive_fifo();
        repeat (200) step();
        for (int i = 0; i < N; i++) begin
            chk_val("drained", i, 64'(fq[i].size()), 64'd0);
            chk_bit("final_busy", i, busy[i], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
